// File: rtl/beat_timer_pkg.sv
// Shared metronome types: beat-period and bar-position widths, run/idle state.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package beat_timer_pkg;

    localparam int BPM_TICKS_W = 26;
    localparam int BAR_W       = 3;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    // Floor a requested beat period so the down-counter can never stall at 0.
    function automatic logic [BPM_TICKS_W-1:0] clamp_ticks(
        input logic [BPM_TICKS_W-1:0] ticks,
        input logic [BPM_TICKS_W-1:0] min_ticks
    );
        return (ticks < min_ticks) ? min_ticks : ticks;
    endfunction

endpackage

// File: rtl/click_tone_gen.sv
// Click envelope plus square-wave tone; a beat (re)starts a full-length click.
// Latency: click_active rises 1 clk after beat; tone starts low, first toggle after one half-period.
// Backpressure: none; a beat during an active click retriggers it from full length.
module click_tone_gen #(
    parameter int CLICK_TICKS      = 1200000,
    parameter int TONE_HALF        = 12000,
    parameter int ACCENT_TONE_HALF = 6000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic beat,
    input  logic accent,
    output logic click_active,
    output logic tone
);

    localparam int HALF_MAX = (TONE_HALF > ACCENT_TONE_HALF) ? TONE_HALF : ACCENT_TONE_HALF;
    localparam int CW       = $clog2(CLICK_TICKS + 1);
    localparam int HW       = $clog2(HALF_MAX + 1);

    logic [CW-1:0] click_cnt;
    logic [HW-1:0] half_cnt;
    logic [HW-1:0] half_load;
    logic          accent_q;
    logic          tone_q;

    // Pitch is chosen from the accent latched at the start of the click.
    assign half_load = accent_q ? HW'(ACCENT_TONE_HALF - 1) : HW'(TONE_HALF - 1);

    // Envelope countdown and tone divider; divider only runs while the click is live.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            click_cnt <= '0;
            half_cnt  <= '0;
            accent_q  <= 1'b0;
            tone_q    <= 1'b0;
        end else if (clear) begin
            click_cnt <= '0;
            half_cnt  <= '0;
            accent_q  <= 1'b0;
            tone_q    <= 1'b0;
        end else if (beat) begin
            click_cnt <= CW'(CLICK_TICKS);
            accent_q  <= accent;
            half_cnt  <= accent ? HW'(ACCENT_TONE_HALF - 1) : HW'(TONE_HALF - 1);
            tone_q    <= 1'b0;
        end else if (click_cnt != '0) begin
            click_cnt <= click_cnt - CW'(1);
            if (half_cnt == '0) begin
                tone_q   <= ~tone_q;
                half_cnt <= half_load;
            end else begin
                half_cnt <= half_cnt - HW'(1);
            end
        end
    end

    assign click_active = (click_cnt != '0);
    // Gate with the envelope so no residual level is left on the speaker pin.
    assign tone = tone_q & click_active;

endmodule

// File: rtl/beat_timer.sv
// Metronome: counts the latched beat period down, emits beat/accent/bar index, drives click tone.
// Latency: first beat 1 clk after enable seen; restart beat 1 clk after strobe; beats eff clocks apart.
// Backpressure: none; bpm_ticks is sampled only at each beat so changes never shorten a beat.
module beat_timer
    import beat_timer_pkg::*;
#(
    parameter int FREQ             = 24000000,
    parameter int CLICK_TICKS      = FREQ / 20,
    parameter int TONE_HALF        = FREQ / 2000,
    parameter int ACCENT_TONE_HALF = FREQ / 4000,
    parameter int MIN_TICKS        = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   restart,
    input  logic [BPM_TICKS_W-1:0] bpm_ticks,
    input  logic [BAR_W-1:0]       beats_per_bar,
    output logic                   beat,
    output logic                   accent,
    output logic [BAR_W-1:0]       beat_index,
    output logic                   click_active,
    output logic                   tone
);

    state_t                 state;
    logic [BPM_TICKS_W-1:0] cnt;
    logic [BPM_TICKS_W-1:0] eff;
    logic [BAR_W-1:0]       next_index;
    logic                   next_accent;

    assign eff = clamp_ticks(bpm_ticks, BPM_TICKS_W'(MIN_TICKS));

    // Bar position for the upcoming beat: restart forces 0, otherwise advance and wrap.
    always_comb begin
        next_index = '0;
        if (!restart && beats_per_bar > BAR_W'(1) &&
            ({1'b0, beat_index} + 4'd1) < {1'b0, beats_per_bar}) begin
            next_index = beat_index + BAR_W'(1);
        end
        next_accent = (next_index == '0) && (beats_per_bar != '0);
    end

    // Run/idle FSM with the beat down-counter and registered beat outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            beat       <= 1'b0;
            accent     <= 1'b0;
            beat_index <= '0;
        end else begin
            case (state)
                IDLE: begin
                    beat       <= 1'b0;
                    accent     <= 1'b0;
                    beat_index <= '0;
                    cnt        <= '0;
                    if (enable) begin
                        state      <= RUN;
                        beat       <= 1'b1;
                        accent     <= (beats_per_bar != '0);
                        beat_index <= '0;
                        cnt        <= eff - BPM_TICKS_W'(1);
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state      <= IDLE;
                        beat       <= 1'b0;
                        accent     <= 1'b0;
                        beat_index <= '0;
                        cnt        <= '0;
                    end else if (restart || cnt == '0) begin
                        beat       <= 1'b1;
                        accent     <= next_accent;
                        beat_index <= next_index;
                        cnt        <= eff - BPM_TICKS_W'(1);
                    end else begin
                        beat   <= 1'b0;
                        accent <= 1'b0;
                        cnt    <= cnt - BPM_TICKS_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    click_tone_gen #(
        .CLICK_TICKS      (CLICK_TICKS),
        .TONE_HALF        (TONE_HALF),
        .ACCENT_TONE_HALF (ACCENT_TONE_HALF)
    ) u_click (
        .clk          (clk),
        .rst          (rst),
        .clear        (~enable),
        .beat         (beat),
        .accent       (accent),
        .click_active (click_active),
        .tone         (tone)
    );

endmodule

// File: tb/tb_beat_timer.sv
// Directed bench for beat_timer with shortened click/tone timing.
// Latency: n/a.
// Backpressure: n/a.
module tb_beat_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        restart;
    logic [25:0] bpm_ticks;
    logic [2:0]  beats_per_bar;
    logic        beat;
    logic        accent;
    logic [2:0]  beat_index;
    logic        click_active;
    logic        tone;

    int checks = 0;
    int errors = 0;

    beat_timer #(
        .FREQ             (24000000),
        .CLICK_TICKS      (20),
        .TONE_HALF        (4),
        .ACCENT_TONE_HALF (2),
        .MIN_TICKS        (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .restart       (restart),
        .bpm_ticks     (bpm_ticks),
        .beats_per_bar (beats_per_bar),
        .beat          (beat),
        .accent        (accent),
        .beat_index    (beat_index),
        .click_active  (click_active),
        .tone          (tone)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Clocks until the next beat strobe, bounded.
    task automatic wait_beat(input int max, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!beat && n < max);
        chk("beat_seen", {31'b0, beat}, 32'd1);
    endtask

    // Record click/tone for 24 clocks after a beat and compare with the expected waveform.
    task automatic tone_window(input string tag, input int half);
        logic [31:0] oc, ot, ec, et;
        oc = '0; ot = '0; ec = '0; et = '0;
        for (int k = 1; k <= 24; k++) begin
            step();
            oc[k-1] = click_active;
            ot[k-1] = tone;
            ec[k-1] = (k <= 20);
            et[k-1] = (k <= 20) && ((((k - 1) / half) % 2) == 1);
        end
        chk({tag, "_click"}, oc, ec);
        chk({tag, "_tone"}, ot, et);
    endtask

    initial begin
        int gap;
        rst = 1'b1; enable = 1'b0; restart = 1'b0;
        bpm_ticks = 26'd10; beats_per_bar = 3'd4;
        step(); step();
        chk("rst_beat",   {31'b0, beat}, 0);
        chk("rst_accent", {31'b0, accent}, 0);
        chk("rst_index",  {29'b0, beat_index}, 0);
        chk("rst_click",  {31'b0, click_active}, 0);
        chk("rst_tone",   {31'b0, tone}, 0);

        rst = 1'b0;
        step();
        chk("idle_beat", {31'b0, beat}, 0);
        enable = 1'b1;
        step();
        chk("first_beat",   {31'b0, beat}, 1);
        chk("first_index",  {29'b0, beat_index}, 0);
        chk("first_accent", {31'b0, accent}, 1);

        // Steady 10-clock gaps, bar of four.
        wait_beat(40, gap); chk("gap1", gap, 10); chk("idx1", {29'b0, beat_index}, 1); chk("acc1", {31'b0, accent}, 0);
        wait_beat(40, gap); chk("gap2", gap, 10); chk("idx2", {29'b0, beat_index}, 2);
        wait_beat(40, gap); chk("gap3", gap, 10); chk("idx3", {29'b0, beat_index}, 3);
        wait_beat(40, gap); chk("gap4", gap, 10); chk("idx4", {29'b0, beat_index}, 0); chk("acc5", {31'b0, accent}, 1);

        // Period change mid-beat: current gap unaffected.
        step(); step(); step();
        bpm_ticks = 26'd6;
        wait_beat(40, gap); chk("midchg_rest", gap, 7); chk("midchg_idx", {29'b0, beat_index}, 1);
        wait_beat(40, gap); chk("new_gap6", gap, 6);

        // Zero period clamps to two clocks.
        bpm_ticks = 26'd0;
        wait_beat(40, gap); chk("pre_clamp_gap", gap, 6);
        wait_beat(40, gap); chk("clamp_gap_a", gap, 2); chk("clamp_acc", {31'b0, accent}, 1);
        bpm_ticks = 26'd10;
        wait_beat(40, gap); chk("clamp_gap_b", gap, 2); chk("clamp_idx", {29'b0, beat_index}, 1);

        // Restart three clocks after a beat.
        step(); step(); step();
        chk("pre_restart_beat", {31'b0, beat}, 0);
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk("restart_beat",   {31'b0, beat}, 1);
        chk("restart_index",  {29'b0, beat_index}, 0);
        chk("restart_accent", {31'b0, accent}, 1);
        wait_beat(40, gap); chk("post_restart_gap", gap, 10); chk("post_restart_idx", {29'b0, beat_index}, 1);

        // No accent with beats_per_bar = 0.
        beats_per_bar = 3'd0;
        wait_beat(40, gap); chk("nobar_gap", gap, 10);
        chk("nobar_idx", {29'b0, beat_index}, 0);
        chk("nobar_acc", {31'b0, accent}, 0);

        // Accented tone (period 4), then normal tone (period 8).
        beats_per_bar = 3'd4; bpm_ticks = 26'd40;
        restart = 1'b1;
        step();
        restart = 1'b0;
        chk("tone_acc_beat", {31'b0, accent}, 1);
        tone_window("accent", 2);
        wait_beat(60, gap); chk("long_gap_rest", gap, 16); chk("long_acc", {31'b0, accent}, 0);
        tone_window("normal", 4);

        // Asynchronous reset during a click.
        wait_beat(60, gap); chk("pre_rst_gap", gap, 16);
        step(); step(); step(); step(); step();
        chk("pre_rst_click", {31'b0, click_active}, 1);
        chk("pre_rst_tone",  {31'b0, tone}, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_click", {31'b0, click_active}, 0);
        chk("async_rst_tone",  {31'b0, tone}, 0);
        chk("async_rst_index", {29'b0, beat_index}, 0);
        rst = 1'b0;
        step();
        chk("post_rst_beat",  {31'b0, beat}, 1);
        chk("post_rst_index", {29'b0, beat_index}, 0);
        chk("post_rst_click", {31'b0, click_active}, 0);

        // Enable drop mid-click, then re-enable.
        wait_beat(60, gap); chk("pre_drop_idx", {29'b0, beat_index}, 1);
        step(); step(); step();
        enable = 1'b0;
        step();
        chk("drop_beat",  {31'b0, beat}, 0);
        chk("drop_index", {29'b0, beat_index}, 0);
        chk("drop_click", {31'b0, click_active}, 0);
        chk("drop_tone",  {31'b0, tone}, 0);
        step(); step();
        chk("idle_no_beat", {31'b0, beat}, 0);
        enable = 1'b1;
        step();
        chk("reen_beat",   {31'b0, beat}, 1);
        chk("reen_index",  {29'b0, beat_index}, 0);
        chk("reen_accent", {31'b0, accent}, 1);
        wait_beat(60, gap); chk("reen_gap", gap, 40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
